// File: rtl/binary_cnn_pkg.sv
// +----------------------------------------------------------------------------+
// | binary_cnn_pkg                                                             |
// | State encoding, tap constants and sizing helpers for the binary classifier.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package binary_cnn_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CONV   = 2'd1;
    localparam logic [1:0] ST_ARGMAX = 2'd2;

    localparam int KDIM = 3;
    localparam int TAPS = KDIM * KDIM;

    function automatic int num_windows(input int w, input int h);
        return (w - 2) * (h - 2);
    endfunction

    // Sized for the worst case: every tap of every window set.
    function automatic int acc_width(input int w, input int h);
        return $clog2(TAPS * num_windows(w, h) + 1);
    endfunction

    function automatic int cls_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/binary_cnn_classifier_popcount9.sv
// +----------------------------------------------------------------------------+
// | popcount9                                                                  |
// | Combinational population count of a 9-bit vector (result 0..9).            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module popcount9 (
    input  logic [8:0] i_bits,
    output logic [3:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < 9; i++) begin
            o_count = o_count + 4'(i_bits[i]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/binary_cnn_classifier.sv
// +----------------------------------------------------------------------------+
// | binary_cnn_classifier                                                      |
// | Slides one 3x3 binary kernel per class over a binary image, accumulates    |
// | AND-popcount scores, then picks the argmax one class per cycle.            |
// | Optional macro SCORE_OUT_EN adds the best_score output port.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module binary_cnn_classifier
    import binary_cnn_pkg::*;
#(
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int NUM_CLASSES = 10
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [IMG_W*IMG_H-1:0]                image_input,
    input  logic [NUM_CLASSES*TAPS-1:0]           kernels,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic [cls_width(NUM_CLASSES)-1:0]     classification
`ifdef SCORE_OUT_EN
    ,
    output logic [acc_width(IMG_W, IMG_H)-1:0]    best_score
`endif
);

    localparam int ACC_W  = acc_width(IMG_W, IMG_H);
    localparam int CLS_W  = cls_width(NUM_CLASSES);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int COL_W  = $clog2(IMG_W);
    localparam int LAST_R = IMG_H - 3;
    localparam int LAST_C = IMG_W - 3;

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic               w_accept;
    logic               w_conv_en;
    logic               w_conv_last;
    logic               w_arg_en;
    logic               w_arg_last;

    logic [IMG_W-1:0]   r_rows [IMG_H];
    logic [TAPS-1:0]    r_kern [NUM_CLASSES];
    logic [ROW_W-1:0]   r_wr;
    logic [COL_W-1:0]   r_wc;
    logic [CLS_W-1:0]   r_idx;
    logic [ACC_W-1:0]   r_acc [NUM_CLASSES];
    logic [ACC_W-1:0]   r_best_val;
    logic [CLS_W-1:0]   r_best_idx;
    logic               r_busy;
    logic               r_done;
    logic [CLS_W-1:0]   r_class;

    logic [TAPS-1:0]    w_window;
    logic [3:0]         w_cnt [NUM_CLASSES];
    logic               w_take;
    logic [ACC_W-1:0]   w_cand_val;
    logic [CLS_W-1:0]   w_cand_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start)       w_next = ST_CONV;
            ST_CONV:   if (w_conv_last) w_next = ST_ARGMAX;
            ST_ARGMAX: if (w_arg_last)  w_next = ST_IDLE;
            default:                    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_accept    = (r_state == ST_IDLE) && start;
        w_conv_en   = (r_state == ST_CONV);
        w_conv_last = w_conv_en && (r_wr == ROW_W'(LAST_R)) && (r_wc == COL_W'(LAST_C));
        w_arg_en    = (r_state == ST_ARGMAX);
        w_arg_last  = w_arg_en && (r_idx == CLS_W'(NUM_CLASSES - 1));
    end

    // Operands are captured once so the source may change during the run.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int r = 0; r < IMG_H; r++) begin
                r_rows[r] <= image_input[r*IMG_W +: IMG_W];
            end
            for (int c = 0; c < NUM_CLASSES; c++) begin
                r_kern[c] <= kernels[c*TAPS +: TAPS];
            end
        end
    end

    always_comb begin
        w_window = '0;
        for (int kr = 0; kr < KDIM; kr++) begin
            for (int kc = 0; kc < KDIM; kc++) begin
                w_window[kr*KDIM + kc] = r_rows[r_wr + ROW_W'(kr)][r_wc + COL_W'(kc)];
            end
        end
    end

    for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_class
        popcount9 u_popcount (
            .i_bits  (w_window & r_kern[g]),
            .o_count (w_cnt[g])
        );
    end

    // Strict compare keeps the earliest index on ties.
    always_comb begin
        w_take     = (r_idx == '0) || (r_acc[r_idx] > r_best_val);
        w_cand_val = w_take ? r_acc[r_idx] : r_best_val;
        w_cand_idx = w_take ? r_idx : r_best_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr       <= '0;
            r_wc       <= '0;
            r_idx      <= '0;
            r_best_val <= '0;
            r_best_idx <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_class    <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                r_acc[c] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_wr       <= '0;
                r_wc       <= '0;
                r_idx      <= '0;
                r_best_val <= '0;
                r_best_idx <= '0;
                r_busy     <= 1'b1;
                for (int c = 0; c < NUM_CLASSES; c++) begin
                    r_acc[c] <= '0;
                end
            end else if (w_conv_en) begin
                for (int c = 0; c < NUM_CLASSES; c++) begin
                    r_acc[c] <= r_acc[c] + ACC_W'(w_cnt[c]);
                end
                if (r_wc == COL_W'(LAST_C)) begin
                    r_wc <= '0;
                    if (!w_conv_last) begin
                        r_wr <= r_wr + 1'b1;
                    end
                end else begin
                    r_wc <= r_wc + 1'b1;
                end
            end else if (w_arg_en) begin
                r_best_val <= w_cand_val;
                r_best_idx <= w_cand_idx;
                r_idx      <= r_idx + 1'b1;
                if (w_arg_last) begin
                    r_class <= w_cand_idx;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            end
        end
    end

`ifdef SCORE_OUT_EN
    logic [ACC_W-1:0] r_score;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_score <= '0;
        end else if (w_arg_last) begin
            r_score <= w_cand_val;
        end
    end

    assign best_score = r_score;
`endif

    assign busy           = r_busy;
    assign done           = r_done;
    assign classification = r_class;

endmodule

`default_nettype wire

// File: tb/tb_binary_cnn_classifier.sv
// +----------------------------------------------------------------------------+
// | tb_binary_cnn_classifier                                                   |
// | Directed and randomized checks of binary_cnn_classifier (8x8, 10 classes). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_binary_cnn_classifier;

    localparam int W     = 8;
    localparam int H     = 8;
    localparam int N     = 10;
    localparam int ACC_W = 9;
    localparam int CLS_W = 4;
    localparam int LAT   = (W - 2) * (H - 2) + N;

    logic              clk;
    logic              rst_n;
    logic [W*H-1:0]    image_input;
    logic [N*9-1:0]    kernels;
    logic              start;
    logic              busy;
    logic              done;
    logic [CLS_W-1:0]  classification;
`ifdef SCORE_OUT_EN
    logic [ACC_W-1:0]  best_score;
`endif

    int n_vec = 0;
    int n_err = 0;

    binary_cnn_classifier #(
        .IMG_W       (W),
        .IMG_H       (H),
        .NUM_CLASSES (N)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .image_input    (image_input),
        .kernels        (kernels),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .classification (classification)
`ifdef SCORE_OUT_EN
        ,
        .best_score     (best_score)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: score every class over every window, then first-maximum wins.
    task automatic model(input logic [W*H-1:0] img, input logic [N*9-1:0] kern,
                         output int cls, output int best);
        int sc;
        best = -1;
        cls  = 0;
        for (int c = 0; c < N; c++) begin
            sc = 0;
            for (int wr = 0; wr <= H - 3; wr++)
                for (int wc = 0; wc <= W - 3; wc++)
                    for (int kr = 0; kr < 3; kr++)
                        for (int kc = 0; kc < 3; kc++)
                            if (img[(wr + kr) * W + wc + kc] && kern[c * 9 + kr * 3 + kc])
                                sc++;
            if (sc > best) begin
                best = sc;
                cls  = c;
            end
        end
    endtask

    task automatic launch(input logic [W*H-1:0] img, input logic [N*9-1:0] kern, input string tag);
        image_input = img;
        kernels     = kern;
        start       = 1'b1;
        step();
        start       = 1'b0;
        image_input = {$urandom, $urandom};
        kernels     = {$urandom, $urandom, $urandom};
        check({tag, "/busy_after_accept"}, 64'(busy), 64'd1);
        check({tag, "/done_low_after_accept"}, 64'(done), 64'd0);
    endtask

    task automatic finish_check(input string tag, input int ecls, input int escore, input bit pulses);
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            start = pulses && (n == 9 || n == 29);
            step();
            n++;
        end
        start = 1'b0;
        check({tag, "/latency"}, 64'(n), 64'(LAT));
        check({tag, "/class"}, 64'(classification), 64'(ecls));
        check({tag, "/busy_at_done"}, 64'(busy), 64'd0);
`ifdef SCORE_OUT_EN
        check({tag, "/score"}, 64'(best_score), 64'(escore));
`endif
    endtask

    task automatic random_run(input logic [W*H-1:0] img, input logic [N*9-1:0] kern, input string tag);
        int ecls, escore;
        model(img, kern, ecls, escore);
        launch(img, kern, tag);
        finish_check(tag, ecls, escore, 1'b0);
    endtask

    initial begin
        logic [W*H-1:0] img;
        logic [N*9-1:0] k;
        int             ndone;
        int             ecls;
        int             escore;

        rst_n       = 1'b0;
        start       = 1'b0;
        image_input = '0;
        kernels     = '0;
        repeat (3) step();
        check("reset/busy", 64'(busy), 64'd0);
        check("reset/done", 64'(done), 64'd0);
        check("reset/class", 64'(classification), 64'd0);
        rst_n = 1'b1;
        step();

        launch('0, {$urandom, $urandom, $urandom}, "zero_img");
        finish_check("zero_img", 0, 0, 1'b0);
        step();
        check("zero_img/done_one_cycle", 64'(done), 64'd0);

        k = '0;
        k[3*9 +: 9] = 9'h1FF;
        launch(64'h80, k, "corner_pixel");
        finish_check("corner_pixel", 3, 1, 1'b0);

        k = '0;
        k[2*9 +: 9] = 9'h007;
        k[5*9 +: 9] = 9'h038;
        launch(64'h00FF00FF00FF00FF, k, "tie");
        finish_check("tie", 2, 54, 1'b0);

        k[7*9 +: 9] = 9'h1FF;
        launch(64'h00FF00FF00FF00FF, k, "full_kernel_pulses");
        finish_check("full_kernel_pulses", 7, 162, 1'b1);
        step();

        img = {$urandom, $urandom};
        launch(img, {$urandom, $urandom, $urandom}, "abort");
        repeat (20) step();
        check("abort/busy_mid_conv", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort/busy", 64'(busy), 64'd0);
        check("abort/done", 64'(done), 64'd0);
        check("abort/class", 64'(classification), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        ndone = 0;
        repeat (60) begin
            step();
            if (done === 1'b1) ndone++;
        end
        check("abort/no_done", 64'(ndone), 64'd0);

        random_run({$urandom, $urandom}, {$urandom, $urandom, $urandom}, "after_abort");

        img = {$urandom, $urandom};
        k   = {$urandom, $urandom, $urandom};
        model(img, k, ecls, escore);
        launch(img, k, "b2b_first");
        finish_check("b2b_first", ecls, escore, 1'b0);
        img = {$urandom, $urandom} | {$urandom, $urandom};
        k   = {$urandom, $urandom, $urandom};
        model(img, k, ecls, escore);
        launch(img, k, "b2b_second");
        finish_check("b2b_second", ecls, escore, 1'b0);

        k = '0;
        k[8:0] = 9'($urandom);
        for (int c = 1; c < N; c++) k[c*9 +: 9] = k[8:0];
        random_run({$urandom, $urandom}, k, "all_equal_kernels");

        for (int i = 0; i < 8; i++) begin
            img = {$urandom, $urandom};
            if (i[0]) img = img & {$urandom, $urandom};
            random_run(img, {$urandom, $urandom, $urandom}, $sformatf("random%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
